alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the decode-side ALU controller, plus two operands.
- Returns a registered result over a valid/ready handshake.
- Sits between decode/issue and writeback.
- Logic ops complete in one cycle; shifts are iterative (1 bit/cycle) unless the barrel-shift option is compiled in.

Parameters:
- XLEN, 32, operand/result width. Must be a power of two, >= 8. Shift amount width SHW = $clog2(XLEN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_control  in  4  operation code (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value or immediate; shamt = operand_b[SHW-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered alongside result

Behaviour:
- Clock/reset: one clock domain; rst is asynchronous, active-high.
- Reset values:
  - state = IDLE
  - out_valid = 0, result = 0, zero = 1
  - in_ready = 1 (combinational, see below)
  - internal shift counter = 0
- Handshakes:
  - A request is accepted on a cycle where in_valid && in_ready. Operands and code are captured on that edge.
  - A result transfers on a cycle where out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue at one op per cycle.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on accept:
    - Non-shift op, or shift with shamt==0: compute, register result, go to DONE. out_valid rises the next cycle (latency 1).
    - Shift with shamt>0: load the working register with operand_a and the counter with shamt, go to SHIFT.
  - SHIFT: each cycle shift the working register 1 bit and decrement the counter. When the counter reaches 1, write the final value into result and go to DONE. Latency = 1 + shamt cycles, e.g. shamt=31 gives out_valid 32 cycles after accept.
  - DONE: out_valid=1.
    - On out_ready with no new accept: go to IDLE, out_valid=0.
    - On out_ready with a simultaneous accept: handle the new op exactly as from IDLE in the same edge. out_valid stays 1 if that op has latency 1.
    - Without out_ready: result, zero and out_valid hold stable.
- Arithmetic: all ops are modulo 2^XLEN.
  - SUB = a + ~b + 1.
  - SLT: signed compare. SLTU: unsigned compare. Both return 1 or 0 zero-extended.
  - SRA replicates bit XLEN-1 of operand_a. Only the low SHW bits of operand_b are used for shifts.
  - Unknown control codes give result 0, zero=1, latency 1.
- in_valid while busy in SHIFT: not accepted (in_ready=0). The requester holds its request.
- Reset mid-operation: asynchronously returns to IDLE. Any in-flight shift result is discarded and never presented.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally in a single cycle, the SHIFT state and counter are not instantiated, and every op has latency 1.
- Undefined: iterative 1-bit/cycle shifting as described above.
- Handshake protocol and results are identical either way; only latency differs.

Decomposition:
- Shared constant file (define_constant.v):
  - ALU code constants ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - FSM state encodings for IDLE/SHIFT/DONE.
  - The unit uses these symbolically and never redefines them.
- One sub-module: alu_shift_unit. It holds the working register, counter and direction/arith control, or the barrel shifter when ALU_BARREL_SHIFT_EN is defined.
- alu_exec_unit holds the FSM, the handshake and the non-shift datapath.

Test Plan:
- Reset asserted mid-SHIFT (SLL, shamt=20, rst at cycle 5) -> out_valid=0, result=0, in_ready=1 immediately. No stale result ever appears.
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, result=0, zero=1. SUB a=5, b=7 -> 0xFFFFFFFE, zero=0.
- SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0. XOR/OR/AND with 0xF0F0F0F0, 0x0FF00FF0 -> 0xFF00FF00 / 0xFFF0FFF0 / 0x00F000F0.
- SRA a=0x80000000, b=0x0000003F (shamt=31):
  - Without the macro: in_ready=0 for 31 cycles, out_valid at +32, result=0xFFFFFFFF.
  - With ALU_BARREL_SHIFT_EN: same result at +1.
- SRL a=0x80000000, shamt=0 -> latency 1, result=0x80000000. SLL a=1, shamt=4 -> 0x10 at +5.
- Backpressure: out_ready=0 for 3 cycles after ADD completes -> result/out_valid stable, in_ready=0. Then out_ready=1 with a new in_valid (OR) -> accepted the same edge, next result presented the following cycle with no bubble.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg
//   Shared constants for the execute-stage ALU: the 4-bit ALU control codes
//   produced by the decode-side ALU controller and the execute FSM states.
//   Users import this package and refer to the codes symbolically.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_shift.sv
// alu_shift_unit
//   Shifter used by alu_exec_unit.
//   Default build: iterative shifter. load_i captures operand, amount and
//   direction; afterwards the working register moves one bit per cycle until
//   the counter drains. step_o is the working value after the next 1-bit step,
//   last_o flags that the next step is the final one.
//   ALU_BARREL_SHIFT_EN defined: purely combinational barrel shifter; step_o
//   is the fully shifted operand and there is no clock, counter or state.
//
//   Ports (iterative build):
//     clk, rst    clock, asynchronous active-high reset
//     load_i      start a shift (shift amount must be non-zero)
//     left_i      1 = SLL, 0 = right shift
//     arith_i     1 = SRA (sign fill) when shifting right
//     operand_i   value to shift
//     shamt_i     shift amount
//     step_o      working register shifted by one bit
//     last_o      counter == 1
//   Ports (barrel build): left_i, arith_i, operand_i, shamt_i, step_o.
module alu_shift_unit #(
  parameter int unsigned XLEN = 32
) (
`ifndef ALU_BARREL_SHIFT_EN
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
`endif
  input  logic                      left_i,
  input  logic                      arith_i,
  input  logic [XLEN-1:0]           operand_i,
  input  logic [$clog2(XLEN)-1:0]   shamt_i,
  output logic [XLEN-1:0]           step_o
`ifndef ALU_BARREL_SHIFT_EN
  ,
  output logic                      last_o
`endif
);

  localparam int unsigned SHW = $clog2(XLEN);

`ifdef ALU_BARREL_SHIFT_EN

  always_comb begin
    step_o = '0;
    if (left_i) begin
      step_o = operand_i << shamt_i;
    end else if (arith_i) begin
      step_o = $unsigned($signed(operand_i) >>> shamt_i);
    end else begin
      step_o = operand_i >> shamt_i;
    end
  end

`else

  logic [XLEN-1:0] work_q;
  logic [SHW-1:0]  cnt_q;
  logic            left_q;
  logic            arith_q;

  always_comb begin
    step_o = '0;
    if (left_q) begin
      step_o = {work_q[XLEN-2:0], 1'b0};
    end else begin
      step_o = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
    end
  end

  assign last_o = (cnt_q == SHW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      work_q  <= operand_i;
      cnt_q   <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (cnt_q != '0) begin
      work_q <= step_o;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU between decode/issue and writeback. Accepts an ALU
//   control code plus two operands over a valid/ready handshake and returns a
//   registered result and zero flag over a second valid/ready handshake.
//   Logic/arithmetic ops take one cycle; shifts take 1 + shamt cycles unless
//   the optional macro ALU_BARREL_SHIFT_EN is defined, in which case every op
//   takes one cycle.
//
//   Ports:
//     clk, rst     clock (rising edge), asynchronous active-high reset
//     in_valid     request valid
//     in_ready     unit can accept a request this cycle (combinational)
//     alu_control  ALU control code (alu_exec_unit_pkg::alu_op_e)
//     operand_a    rs1 value
//     operand_b    rs2 value / immediate; shift amount = low $clog2(XLEN) bits
//     out_valid    result valid
//     out_ready    consumer accepts result
//     result       registered result
//     zero         result == 0, registered alongside result
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            out_valid_q;

  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            start_shift;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] alu_res_d;

  assign shamt     = operand_b[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

`ifdef ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;

  alu_shift_unit #(.XLEN(XLEN)) u_shift (
    .left_i    (alu_control == ALU_SLL),
    .arith_i   (alu_control == ALU_SRA),
    .operand_i (operand_a),
    .shamt_i   (shamt),
    .step_o    (shift_res)
  );
`else
  logic shift_last;

  assign start_shift = accept && is_shift_op(alu_control) && (shamt != '0);

  alu_shift_unit #(.XLEN(XLEN)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load_i    (start_shift),
    .left_i    (alu_control == ALU_SLL),
    .arith_i   (alu_control == ALU_SRA),
    .operand_i (operand_a),
    .shamt_i   (shamt),
    .step_o    (shift_res),
    .last_o    (shift_last)
  );
`endif

  // Single-cycle datapath for the op presented at the input.
  always_comb begin
    alu_res_d = '0;
    case (alu_control)
      ALU_ADD:  alu_res_d = operand_a + operand_b;
      ALU_SUB:  alu_res_d = operand_a + ~operand_b + XLEN'(1);
      ALU_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      ALU_XOR:  alu_res_d = operand_a ^ operand_b;
      ALU_OR:   alu_res_d = operand_a | operand_b;
      ALU_AND:  alu_res_d = operand_a & operand_b;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res_d = shift_res;
`else
      // Only shamt == 0 completes here; non-zero amounts go through ST_SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res_d = operand_a;
`endif
      default:  alu_res_d = '0;
    endcase
  end

  // An accept can only happen in IDLE or in DONE with out_ready, so it is
  // handled first; it covers the back-to-back DONE -> DONE/SHIFT transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        state_q     <= ST_SHIFT;
        out_valid_q <= 1'b0;
      end else begin
        result_q    <= alu_res_d;
        zero_q      <= (alu_res_d == '0);
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
`ifndef ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          if (shift_last) begin
            result_q    <= shift_res;
            zero_q      <= (shift_res == '0);
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed self-checking bench for alu_exec_unit (XLEN = 32). Expected
//   latencies depend on whether ALU_BARREL_SHIFT_EN is defined.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'h0; operand_a = '0; operand_b = '0;
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [9] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, 4'hF, ALU_SUB};
    logic [31:0] va  [9] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                             32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h0};
    logic [31:0] vb  [9] = '{32'h1, 32'd7, 32'h1, 32'h1, 32'h0FF00FF0,
                             32'h0FF00FF0, 32'h0FF00FF0, 32'h1, 32'h1};
    logic [31:0] ve  [9] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'hFF00FF00,
                             32'hFFF0FFF0, 32'h00F000F0, 32'h0, 32'hFFFFFFFF};
    logic        vz  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      alu_control = ops[i]; operand_a = va[i]; operand_b = vb[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL op%0d_latency out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (result !== ve[i]) begin n_bad++; $display("FAIL op%0d_result got %h want %h", i, result, ve[i]); end
      n_cmp++; if (zero !== vz[i]) begin n_bad++; $display("FAIL op%0d_zero got %b want %b", i, zero, vz[i]); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ops_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [5] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRL, ALU_SRA};
    logic [31:0] va  [5] = '{32'h80000000, 32'h80000000, 32'h1, 32'hF0000000, 32'h40000000};
    logic [31:0] vb  [5] = '{32'h3F, 32'h20, 32'h4, 32'h4, 32'h1};
    logic [31:0] ve  [5] = '{32'hFFFFFFFF, 32'h80000000, 32'h10, 32'h0F000000, 32'h20000000};
    int unsigned vl  [5] = '{32, 1, 5, 5, 2};
    int unsigned lat;
    int unsigned low;
    int unsigned exp_lat;
    for (int i = 0; i < 5; i++) begin
      exp_lat = BARREL ? 1 : vl[i];
      out_ready = 1'b0;
      alu_control = ops[i]; operand_a = va[i]; operand_b = vb[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1; low = 0;
      while (!out_valid && lat < 100) begin
        if (!in_ready) low++;
        tick();
        lat++;
      end
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL shift%0d_latency got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (low !== exp_lat - 1) begin n_bad++; $display("FAIL shift%0d_busy_cycles got %0d want %0d", i, low, exp_lat - 1); end
      n_cmp++; if (result !== ve[i]) begin n_bad++; $display("FAIL shift%0d_result got %h want %h", i, result, ve[i]); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL shift%0d_zero got %b want 0", i, zero); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL shift%0d_drain out_valid got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int unsigned stale;
    out_ready = 1'b1;
    alu_control = ALU_SLL; operand_a = 32'h1; operand_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_pre out_valid got %b want 0", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL midrst_result got %h want 00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL midrst_zero got %b want 1", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    #1 rst = 1'b0;
    stale = 0;
    repeat (30) begin
      tick();
      if (out_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL midrst_stale_cycles got %0d want 0", stale); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    alu_control = ALU_ADD; operand_a = 32'd2; operand_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_first out_valid got %b want 1", out_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d out_valid got %b want 1", c, out_valid); end
      n_cmp++; if (result !== 32'd5) begin n_bad++; $display("FAIL bp_hold%0d result got %h want 00000005", c, result); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d in_ready got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    alu_control = ALU_OR; operand_a = 32'h000000F0; operand_b = 32'h0000000F; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next out_valid got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'hFF) begin n_bad++; $display("FAIL bp_next result got %h want 000000ff", result); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{ALU_ADD, ALU_SUB, ALU_XOR};
    logic [31:0] va  [3] = '{32'd1, 32'd10, 32'hFFFFFFFF};
    logic [31:0] vb  [3] = '{32'd1, 32'd3, 32'hFFFFFFFF};
    logic [31:0] ve  [3] = '{32'd2, 32'd7, 32'd0};
    logic        vz  [3] = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_control = ops[i]; operand_a = va[i]; operand_b = vb[i]; in_valid = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b%0d out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (result !== ve[i]) begin n_bad++; $display("FAIL b2b%0d result got %h want %h", i, result, ve[i]); end
      n_cmp++; if (zero !== vz[i]) begin n_bad++; $display("FAIL b2b%0d zero got %b want %b", i, zero, vz[i]); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_hold_while_shifting();
    int unsigned lat;
    int unsigned exp_lat;
    exp_lat = BARREL ? 1 : 3;
    out_ready = 1'b1;
    alu_control = ALU_SLL; operand_a = 32'd3; operand_b = 32'd2; in_valid = 1'b1;
    tick();
    alu_control = ALU_ADD; operand_a = 32'd7; operand_b = 32'd8;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL hold_latency got %0d want %0d", lat, exp_lat); end
    n_cmp++; if (result !== 32'hC) begin n_bad++; $display("FAIL hold_shift_result got %h want 0000000c", result); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_add out_valid got %b want 1", out_valid); end
    n_cmp++; if (result !== 32'd15) begin n_bad++; $display("FAIL hold_add_result got %h want 0000000f", result); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_drain out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_shifts();
    test_reset_mid_shift();
    test_backpressure();
    test_back_to_back();
    test_hold_while_shifting();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
